data_memory_ctrl: RTL and testbench

//   Parametrised synchronous data memory for the MIPS datapath MEM stage. Byte-addressed,

---
 rtl/data_memory_ctrl.sv | 172 +++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Data memory for the MEM stage: byte-addressed, word-organised storage with
// byte/half/word loads and stores, load extension, alignment/range checking
// and a fixed-latency request/Ready handshake for pipeline stalls.
module data_memory_ctrl #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        AddrError
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef logic [31:0] mem_t [DEPTH_WORDS];

  // Power-up image: the first three words hold small negative constants the
  // datapath tests rely on; everything else starts at zero.
  function automatic mem_t init_image();
    mem_t img;
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      img[i] = 32'h0;
    end
    img[0] = 32'hFFFF_FFFF;
    img[1] = 32'hFFFF_FFFC;
    img[2] = 32'hFFFF_FFFB;
    return img;
  endfunction

  mem_t mem = init_image();

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;

  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic        lat_write;

  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;
  logic [1:0]  eff_size;
  logic        eff_unsigned;
  logic        eff_write;
  logic        err;
  logic        commit;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic [31:0] rd_word;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  // With zero wait states the commit happens on the accepting edge, so the
  // live request inputs are used in IDLE and the latched copy afterwards.
  assign eff_addr     = (state == S_IDLE) ? Address   : lat_addr;
  assign eff_wdata    = (state == S_IDLE) ? WriteData : lat_wdata;
  assign eff_size     = (state == S_IDLE) ? Size      : lat_size;
  assign eff_unsigned = (state == S_IDLE) ? Unsigned  : lat_unsigned;
  assign eff_write    = (state == S_IDLE) ? MemWrite  : lat_write;

  assign idx     = eff_addr[AW+1:2];
  assign lane    = eff_addr[1:0];
  assign rd_word = mem[idx];
  assign shifted = rd_word >> {lane, 3'b000};
  assign commit  = (state_next == S_DONE) && (state != S_DONE);
  assign Ready   = (state == S_DONE);

  // Next-state logic: IDLE accepts, WAIT counts down, DONE lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (MemRead || MemWrite) begin
          state_next = (WAIT_STATES > 0) ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd1) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Access checking and load lane selection with sign/zero extension.
  always_comb begin
    err      = 1'b0;
    load_ext = rd_word;
    if (eff_addr[31:AW+2] != '0) begin
      err = 1'b1;
    end
    case (eff_size)
      2'b00: load_ext = {{24{~eff_unsigned & shifted[7]}}, shifted[7:0]};
      2'b01: begin
        load_ext = {{16{~eff_unsigned & shifted[15]}}, shifted[15:0]};
        if (eff_addr[0]) begin
          err = 1'b1;
        end
      end
      2'b10: begin
        load_ext = rd_word;
        if (eff_addr[1:0] != 2'b00) begin
          err = 1'b1;
        end
      end
      default: err = 1'b1;
    endcase
  end

  // State, latches, result registers and array writes; reset aborts any
  // access in flight and never touches the array contents.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= S_IDLE;
      wait_cnt     <= 4'd0;
      ReadData     <= 32'h0;
      AddrError    <= 1'b0;
      lat_addr     <= 32'h0;
      lat_wdata    <= 32'h0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_write    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && (MemRead || MemWrite)) begin
        lat_addr     <= Address;
        lat_wdata    <= WriteData;
        lat_size     <= Size;
        lat_unsigned <= Unsigned;
        lat_write    <= MemWrite;
        wait_cnt     <= 4'(WAIT_STATES);
      end else if (state == S_WAIT && wait_cnt != 4'd1) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (commit) begin
        AddrError <= err;
        if (eff_write) begin
          if (!err) begin
            case (eff_size)
              2'b00:   mem[idx][{lane, 3'b000} +: 8]     <= eff_wdata[7:0];
              2'b01:   mem[idx][{lane[1], 4'b0000} +: 16] <= eff_wdata[15:0];
              default: mem[idx]                          <= eff_wdata;
            endcase
          end
        end else begin
          ReadData <= err ? 32'h0 : load_ext;
        end
      end else if (state == S_DONE) begin
        AddrError <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Testbench for data_memory_ctrl: two instances (zero and three wait states)
// driven by directed and random accesses, checked against an array model.
module tb_data_memory_ctrl;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst;
  logic        mem_read   [2];
  logic        mem_write  [2];
  logic [31:0] address    [2];
  logic [31:0] write_data [2];
  logic [1:0]  size_sel   [2];
  logic        uns        [2];
  logic [31:0] read_data  [2];
  logic        ready      [2];
  logic        addr_error [2];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [2][DEPTH];
  logic [31:0] exp_rd [2];
  logic [31:0] obs;

  data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .Clk(clk), .Reset(rst), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
    .Address(address[0]), .WriteData(write_data[0]), .Size(size_sel[0]),
    .Unsigned(uns[0]), .ReadData(read_data[0]), .Ready(ready[0]),
    .AddrError(addr_error[0])
  );

  data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut3 (
    .Clk(clk), .Reset(rst), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
    .Address(address[1]), .WriteData(write_data[1]), .Size(size_sel[1]),
    .Unsigned(uns[1]), .ReadData(read_data[1]), .Ready(ready[1]),
    .AddrError(addr_error[1])
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic modelErr(input logic [31:0] addr, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    if (addr >= 4 * DEPTH) return 1'b1;
    if (sz == 2'd1 && (addr % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (addr % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelLoad(input int inst, input logic [31:0] addr,
                                            input logic [1:0] sz, input logic u);
    logic [31:0] w;
    logic [31:0] v;
    w = model_mem[inst][addr / 4];
    v = w >> (8 * (addr % 4));
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (!u && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (!u && v >= 32768) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic modelStore(input int inst, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] mask;
    int sh;
    sh   = 8 * (addr % 4);
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    model_mem[inst][addr / 4] = (model_mem[inst][addr / 4] & ~(mask << sh)) |
                                ((wd & mask) << sh);
  endtask

  // One complete access: drive, wait for Ready within a bound, compare
  // latency/result/error against the model, release and confirm Ready drops.
  task automatic applyStimulus(input int inst, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [1:0] sz, input logic u,
                               output logic [31:0] rd_obs);
    int   ws;
    int   cycles;
    logic got;
    logic exp_err;
    ws      = (inst == 0) ? 0 : 3;
    cycles  = 0;
    got     = 1'b0;
    exp_err = modelErr(addr, sz);
    if (wr) begin
      if (!exp_err) modelStore(inst, addr, wd, sz);
    end else begin
      exp_rd[inst] = exp_err ? 32'h0 : modelLoad(inst, addr, sz, u);
    end
    mem_read[inst]   = rd;
    mem_write[inst]  = wr;
    address[inst]    = addr;
    write_data[inst] = wd;
    size_sel[inst]   = sz;
    uns[inst]        = u;
    while (!got && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
      if (ready[inst]) begin
        got = 1'b1;
      end else if (cycles == 1) begin
        address[inst]    = $urandom;
        write_data[inst] = $urandom;
        size_sel[inst]   = 2'($urandom_range(0, 3));
        uns[inst]        = 1'($urandom_range(0, 1));
      end
    end
    checkOutput("ready_seen", 32'(got), 32'd1);
    if (got) begin
      checkOutput("latency", cycles, ws + 1);
      checkOutput("read_data", read_data[inst], exp_rd[inst]);
      checkOutput("addr_error", 32'(addr_error[inst]), 32'(exp_err));
    end
    rd_obs          = read_data[inst];
    mem_read[inst]  = 1'b0;
    mem_write[inst] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ready_drop", 32'(ready[inst]), 32'd0);
  endtask

  // Directed scenarios followed by randomized traffic on both instances.
  initial begin
    int pulses;
    int gap;
    int op;
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      mem_read[i] = 1'b0; mem_write[i] = 1'b0; address[i] = 32'h0;
      write_data[i] = 32'h0; size_sel[i] = 2'b10; uns[i] = 1'b0;
      exp_rd[i] = 32'h0;
      for (int w = 0; w < DEPTH; w++) model_mem[i][w] = 32'h0;
      model_mem[i][0] = 32'hFFFF_FFFF;
      model_mem[i][1] = 32'hFFFF_FFFC;
      model_mem[i][2] = 32'hFFFF_FFFB;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(ready[0]), 32'd0);
    checkOutput("rst_err", 32'(addr_error[0]), 32'd0);
    checkOutput("rst_rdata", read_data[0], 32'h0);
    rst = 1'b0;

    applyStimulus(0, 1, 0, 32'h0, 32'h0, 2'd2, 0, obs);
    checkOutput("t1_lw0", obs, 32'hFFFF_FFFF);

    applyStimulus(0, 0, 1, 32'h10, 32'h1234_5678, 2'd2, 0, obs);
    applyStimulus(0, 1, 0, 32'h13, 32'h0, 2'd0, 0, obs);
    checkOutput("t2_lb", obs, 32'h0000_0012);
    applyStimulus(0, 1, 0, 32'h12, 32'h0, 2'd1, 0, obs);
    checkOutput("t2_lh", obs, 32'h0000_1234);
    applyStimulus(0, 1, 0, 32'h10, 32'h0, 2'd0, 1, obs);
    checkOutput("t2_lbu", obs, 32'h0000_0078);

    applyStimulus(0, 0, 1, 32'h21, 32'h0000_0080, 2'd0, 0, obs);
    applyStimulus(0, 1, 0, 32'h21, 32'h0, 2'd0, 0, obs);
    checkOutput("t3_lb", obs, 32'hFFFF_FF80);
    applyStimulus(0, 1, 0, 32'h21, 32'h0, 2'd0, 1, obs);
    checkOutput("t3_lbu", obs, 32'h0000_0080);
    applyStimulus(0, 1, 0, 32'h20, 32'h0, 2'd2, 0, obs);
    checkOutput("t3_lw", obs, 32'h0000_8000);

    applyStimulus(0, 1, 0, 32'h6, 32'h0, 2'd2, 0, obs);
    checkOutput("t4_misaligned_rdata", obs, 32'h0);
    applyStimulus(0, 0, 1, 32'h100, 32'hA5A5_A5A5, 2'd2, 0, obs);
    applyStimulus(0, 1, 0, 32'h0, 32'h0, 2'd2, 0, obs);
    checkOutput("t4_word0_kept", obs, 32'hFFFF_FFFF);

    // Held request on the slow instance: Ready after 4 edges, then 5 more.
    exp_rd[1] = modelLoad(1, 32'h4, 2'd2, 1'b0);
    mem_read[1] = 1'b1; address[1] = 32'h4; size_sel[1] = 2'd2; uns[1] = 1'b0;
    gap = 0;
    do begin @(posedge clk); #1; gap++; end while (!ready[1] && gap < 20);
    checkOutput("t5_first_latency", gap, 4);
    checkOutput("t5_first_rdata", read_data[1], 32'hFFFF_FFFC);
    gap = 0;
    do begin @(posedge clk); #1; gap++; end while (!ready[1] && gap < 20);
    checkOutput("t5_second_gap", gap, 5);
    checkOutput("t5_second_rdata", read_data[1], exp_rd[1]);
    mem_read[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a slow store: no Ready, no write.
    mem_write[1] = 1'b1; address[1] = 32'h8; write_data[1] = 32'hDEAD_BEEF;
    size_sel[1] = 2'd2;
    pulses = 0;
    repeat (2) begin @(posedge clk); #1; if (ready[1]) pulses++; end
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (ready[1]) pulses++; end
    mem_write[1] = 1'b0;
    rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (ready[1]) pulses++; end
    checkOutput("t6_no_ready", pulses, 0);
    checkOutput("t6_rst_rdata0", read_data[0], 32'h0);
    checkOutput("t6_rst_rdata1", read_data[1], 32'h0);
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    applyStimulus(1, 1, 0, 32'h8, 32'h0, 2'd2, 0, obs);
    checkOutput("t6_store_aborted", obs, 32'hFFFF_FFFB);

    for (int n = 0; n < 240; n++) begin
      int inst;
      inst = n % 2;
      op   = $urandom_range(0, 4);
      a    = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH + 7));
      applyStimulus(inst, op != 2 && op != 3, op >= 2, a, $urandom,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), obs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
